// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier retiring BITS_PER_CYCLE bits of b per cycle,
// unsigned or two's complement, with a valid/ready operand and result handshake.
module seq_multiplier #(
  parameter int WIDTH_A        = 10,
  parameter int WIDTH_B        = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  input  logic                       signed_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] c,
  output logic [1:0]                 dbg_state_o
);

  localparam int WIDTH_C = WIDTH_A + WIDTH_B;
  localparam int STEPS   = (WIDTH_B + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int SW      = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0]      LAST_STEP = SW'(STEPS - 1);
  localparam logic [WIDTH_B-1:0] MSB_MARK  = WIDTH_B'(1) << (WIDTH_B - 1);

  // Handshake: an operation transfers on a rising edge with in_valid && in_ready
  // (in_ready is high only in IDLE); a result transfers on a rising edge with
  // out_valid && out_ready (out_valid is high only in DONE, c held until then).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH_C-1:0] a_q, a_d;
  logic [WIDTH_C-1:0] acc_q, acc_d;
  logic [WIDTH_C-1:0] c_q, c_d;
  logic [WIDTH_B-1:0] b_q, b_d;
  logic [WIDTH_B-1:0] msb_q, msb_d;
  logic               mode_q, mode_d;
  logic [SW-1:0]      step_q, step_d;

  logic [WIDTH_C-1:0] pp_a;
  logic [WIDTH_B-1:0] pp_b;
  logic [WIDTH_B-1:0] pp_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      b_q     <= '0;
      msb_q   <= '0;
      mode_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      b_q     <= b_d;
      msb_q   <= msb_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    c_d     = c_q;
    b_d     = b_q;
    msb_d   = msb_q;
    mode_d  = mode_q;
    step_d  = step_q;
    pp_a    = a_q;
    pp_b    = b_q;
    pp_m    = msb_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = signed_mode ? {{WIDTH_B{a[WIDTH_A-1]}}, a} : {{WIDTH_B{1'b0}}, a};
          b_d     = b;
          msb_d   = MSB_MARK;
          mode_d  = signed_mode;
          acc_d   = '0;
          step_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // a shifts left and b shifts right so bit 0 of b always pairs with the
        // correctly weighted a; msb marks b's sign bit, whose product is negative.
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
          if (pp_b[0]) begin
            if (mode_q && pp_m[0]) acc_d = acc_d - pp_a;
            else                   acc_d = acc_d + pp_a;
          end
          pp_a = pp_a << 1;
          pp_b = pp_b >> 1;
          pp_m = pp_m >> 1;
        end
        a_d    = pp_a;
        b_d    = pp_b;
        msb_d  = pp_m;
        step_d = step_q + SW'(1);
        if (step_q == LAST_STEP) begin
          c_d     = acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign c           = c_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: three radix instances (1, 3, 8 bits per cycle) sharing
// operand buses, with an expected-product queue filled at issue and drained at out_valid.
module tb_seq_multiplier;

  localparam int WA = 10;
  localparam int WB = 8;
  localparam int WC = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic          mode;
  logic [2:0]    in_valid_v;
  logic [2:0]    out_ready_v;
  logic [2:0]    in_ready_v;
  logic [2:0]    out_valid_v;
  logic [WC-1:0] c_v [3];
  logic [1:0]    st_v [3];

  logic [WC-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH_A(WA), .WIDTH_B(WB), .BITS_PER_CYCLE(1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .signed_mode(mode), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .c(c_v[0]), .dbg_state_o(st_v[0])
  );

  seq_multiplier #(.WIDTH_A(WA), .WIDTH_B(WB), .BITS_PER_CYCLE(3)) u_r3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .signed_mode(mode), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .c(c_v[1]), .dbg_state_o(st_v[1])
  );

  seq_multiplier #(.WIDTH_A(WA), .WIDTH_B(WB), .BITS_PER_CYCLE(8)) u_r8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .signed_mode(mode), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .c(c_v[2]), .dbg_state_o(st_v[2])
  );

  function automatic logic [WC-1:0] model(input logic [WA-1:0] x, input logic [WB-1:0] y,
                                          input logic m);
    longint p;
    if (m) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'(x) * longint'(y);
    return WC'(p);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_op(input int k, input logic [WA-1:0] aa, input logic [WB-1:0] bb,
                         input logic mm);
    a = aa;
    b = bb;
    mode = mm;
    in_valid_v[k] = 1'b1;
    exp_q.push_back(model(aa, bb, mm));
    @(negedge clk);
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (out_valid_v[k] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid_v[k] !== 1'b1) lat = -1;
  endtask

  task automatic release_out(input int k);
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
  endtask

  function automatic logic [WC-1:0] pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    a = '0; b = '0; mode = 1'b0;
    in_valid_v = '0; out_ready_v = '0;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (in_ready_v[k] !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready_v[k]);
      end
      n_cmp++;
      if (out_valid_v[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid_v[k]);
      end
      n_cmp++;
      if (c_v[k] !== '0) begin
        n_fail++; $display("FAIL reset_c[%0d]: got %h want 0", k, c_v[k]);
      end
      n_cmp++;
      if (st_v[k] !== 2'd0) begin
        n_fail++; $display("FAIL reset_state[%0d]: got %0d want 0", k, st_v[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    logic [WC-1:0] exp;
    for (int i = 0; i < 7; i++) begin
      logic [WA-1:0] aa;
      logic [WB-1:0] bb;
      aa = (i == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
      bb = (i == 0) ? 8'd255   : 8'($urandom_range(0, 255));
      n_cmp++;
      if (in_ready_v[0] !== 1'b1) begin
        n_fail++; $display("FAIL unsigned_in_ready: got %b want 1", in_ready_v[0]);
      end
      send_op(0, aa, bb, 1'b0);
      wait_done(0, lat);
      exp = pop_exp();
      n_cmp++;
      if (lat !== 8) begin
        n_fail++; $display("FAIL unsigned_latency a=%0d b=%0d: got %0d want 8", aa, bb, lat);
      end
      n_cmp++;
      if (c_v[0] !== exp) begin
        n_fail++; $display("FAIL unsigned_c a=%0d b=%0d: got %h want %h", aa, bb, c_v[0], exp);
      end
      if (i == 0) begin
        n_cmp++;
        if (c_v[0] !== 18'h3FB01) begin
          n_fail++; $display("FAIL unsigned_full_scale: got %h want 3fb01", c_v[0]);
        end
      end
      release_out(0);
      n_cmp++;
      if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
        n_fail++; $display("FAIL unsigned_release: got valid=%b ready=%b want 0/1",
                           out_valid_v[0], in_ready_v[0]);
      end
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [WC-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      logic [WA-1:0] aa;
      logic [WB-1:0] bb;
      case (i)
        0:       begin aa = 10'h200; bb = 8'h80; end
        1:       begin aa = 10'd3;   bb = 8'hFF; end
        2:       begin aa = 10'h1FF; bb = 8'h80; end
        3:       begin aa = 10'h200; bb = 8'h7F; end
        default: begin aa = 10'($urandom_range(0, 1023)); bb = 8'($urandom_range(0, 255)); end
      endcase
      send_op(0, aa, bb, 1'b1);
      wait_done(0, lat);
      exp = pop_exp();
      n_cmp++;
      if (lat !== 8) begin
        n_fail++; $display("FAIL signed_latency a=%h b=%h: got %0d want 8", aa, bb, lat);
      end
      n_cmp++;
      if (c_v[0] !== exp) begin
        n_fail++; $display("FAIL signed_c a=%h b=%h: got %h want %h", aa, bb, c_v[0], exp);
      end
      if (i == 0) begin
        n_cmp++;
        if (c_v[0] !== 18'h10000) begin
          n_fail++; $display("FAIL signed_extreme: got %h want 10000", c_v[0]);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (c_v[0] !== 18'h3FFFD) begin
          n_fail++; $display("FAIL signed_minus_one: got %h want 3fffd", c_v[0]);
        end
      end
      release_out(0);
    end
  endtask

  task automatic test_radix();
    int lat;
    int exp_lat;
    logic [WC-1:0] exp;
    for (int k = 1; k < 3; k++) begin
      exp_lat = (k == 1) ? 3 : 1;
      for (int i = 0; i < 5; i++) begin
        logic [WA-1:0] aa;
        logic [WB-1:0] bb;
        logic          mm;
        aa = (i == 0) ? 10'd100 : 10'($urandom_range(0, 1023));
        bb = (i == 0) ? 8'd200  : 8'($urandom_range(0, 255));
        mm = (i == 0) ? 1'b0    : 1'($urandom_range(0, 1));
        if (i == 1) begin aa = 10'h200; bb = 8'h80; mm = 1'b1; end
        send_op(k, aa, bb, mm);
        wait_done(k, lat);
        exp = pop_exp();
        n_cmp++;
        if (lat !== exp_lat) begin
          n_fail++; $display("FAIL radix_latency[%0d]: got %0d want %0d", k, lat, exp_lat);
        end
        n_cmp++;
        if (c_v[k] !== exp) begin
          n_fail++; $display("FAIL radix_c[%0d] a=%h b=%h s=%b: got %h want %h",
                             k, aa, bb, mm, c_v[k], exp);
        end
        if (i == 0) begin
          n_cmp++;
          if (c_v[k] !== 18'd20000) begin
            n_fail++; $display("FAIL radix_20000[%0d]: got %0d want 20000", k, c_v[k]);
          end
        end
        release_out(k);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [WC-1:0] exp;
    send_op(0, 10'd611, 8'd147, 1'b0);
    wait_done(0, lat);
    exp = pop_exp();
    for (int i = 0; i < 5; i++) begin
      a = 10'($urandom_range(0, 1023));
      b = 8'($urandom_range(0, 255));
      mode = ~mode;
      in_valid_v[0] = ~in_valid_v[0];
      @(negedge clk);
      n_cmp++;
      if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || c_v[0] !== exp) begin
        n_fail++; $display("FAIL backpressure_hold[%0d]: got valid=%b ready=%b c=%h want 1/0/%h",
                           i, out_valid_v[0], in_ready_v[0], c_v[0], exp);
      end
    end
    in_valid_v[0] = 1'b0;
    release_out(0);
    n_cmp++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release: got ready=%b valid=%b want 1/0",
                         in_ready_v[0], out_valid_v[0]);
    end
    n_cmp++;
    if (c_v[0] !== exp) begin
      n_fail++; $display("FAIL backpressure_c_retained: got %h want %h", c_v[0], exp);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [WC-1:0] exp;
    out_ready_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [WA-1:0] aa;
      logic [WB-1:0] bb;
      logic          mm;
      aa = 10'($urandom_range(0, 1023));
      bb = 8'($urandom_range(0, 255));
      mm = 1'(i);
      n_cmp++;
      if (in_ready_v[0] !== 1'b1) begin
        n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready_v[0]);
      end
      send_op(0, aa, bb, mm);
      wait_done(0, lat);
      exp = pop_exp();
      n_cmp++;
      if (lat !== 8) begin
        n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want 8", i, lat);
      end
      n_cmp++;
      if (c_v[0] !== exp || in_ready_v[0] !== 1'b0) begin
        n_fail++; $display("FAIL b2b_c[%0d]: got c=%h ready=%b want %h/0", i, c_v[0], in_ready_v[0], exp);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid_v[0] !== 1'b0 || c_v[0] !== exp) begin
        n_fail++; $display("FAIL b2b_return[%0d]: got valid=%b c=%h want 0/%h",
                           i, out_valid_v[0], c_v[0], exp);
      end
    end
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [WC-1:0] exp;
    send_op(0, 10'd7, 8'd9, 1'b0);
    wait_done(0, lat);
    exp = pop_exp();
    release_out(0);
    send_op(0, 10'd500, 8'd200, 1'b0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid_v[0] !== 1'b0 || c_v[0] !== '0 || in_ready_v[0] !== 1'b1 || st_v[0] !== 2'd0) begin
      n_fail++; $display("FAIL midreset_async: got valid=%b c=%h ready=%b st=%0d want 0/0/1/0",
                         out_valid_v[0], c_v[0], in_ready_v[0], st_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid_v[0] === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL midreset_no_valid: got %0d valid cycles want 0", seen);
    end
    send_op(0, 10'd5, 8'd7, 1'b0);
    wait_done(0, lat);
    exp = pop_exp();
    n_cmp++;
    if (lat !== 8 || c_v[0] !== exp || c_v[0] !== 18'd35) begin
      n_fail++; $display("FAIL midreset_next_op: got lat=%0d c=%0d want 8/35", lat, c_v[0]);
    end
    release_out(0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_radix();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
